// File: rtl/host_descriptor_queue.sv
// Descriptor FIFO between host injection control and downstream forwarding.
// Decouples two wr/ack handshakes and exposes occupancy/watermark/traffic stats.
module host_descriptor_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [39:0]       iv_descriptor,
    input  logic              i_descriptor_wr,
    output logic              o_descriptor_ack,
    output logic [39:0]       ov_descriptor,
    output logic              o_descriptor_wr,
    input  logic              i_descriptor_ack,
    input  logic [ADDR_W:0]   iv_afull_threshold,
    input  logic              i_watermark_clr,
    output logic [ADDR_W:0]   ov_usedw,
    output logic [ADDR_W:0]   ov_max_usedw,
    output logic              o_full,
    output logic              o_afull,
    output logic [15:0]       ov_in_cnt,
    output logic [15:0]       ov_out_cnt
);

    localparam int unsigned UW = ADDR_W + 1;
    localparam int unsigned DW = 40;
    localparam int unsigned CW = 16;

    typedef enum logic {
        O_IDLE = 1'b0,
        O_WAIT = 1'b1
    } out_state_t;

    out_state_t         state;
    logic [DW-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0]  wp;
    logic [ADDR_W-1:0]  rp;

    logic               accept_c;
    logic               pop_c;
    logic [UW-1:0]      usedw_nxt_c;

    // The ack-low qualifier keeps a still-high wr from being accepted twice.
    assign accept_c    = i_descriptor_wr && !o_descriptor_ack && (ov_usedw < UW'(DEPTH));
    assign pop_c       = (state == O_WAIT) && i_descriptor_ack;
    assign usedw_nxt_c = ov_usedw + UW'(accept_c) - UW'(pop_c);

    // Storage array; contents need no reset since usedw gates every read.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept_c) begin
            mem[wp] <= iv_descriptor;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= O_IDLE;
            wp               <= '0;
            rp               <= '0;
            o_descriptor_ack <= 1'b0;
            ov_descriptor    <= '0;
            o_descriptor_wr  <= 1'b0;
            ov_usedw         <= '0;
            ov_max_usedw     <= '0;
            o_full           <= 1'b0;
            o_afull          <= 1'b0;
            ov_in_cnt        <= '0;
            ov_out_cnt       <= '0;
        end else begin
            o_descriptor_ack <= accept_c;
            if (accept_c) begin
                wp        <= wp + ADDR_W'(1);
                ov_in_cnt <= ov_in_cnt + CW'(1);
            end

            // Flags and watermark follow the next occupancy so they align with usedw.
            ov_usedw <= usedw_nxt_c;
            o_full   <= (usedw_nxt_c == UW'(DEPTH));
            o_afull  <= (usedw_nxt_c >= iv_afull_threshold);
            if (i_watermark_clr) begin
                ov_max_usedw <= usedw_nxt_c;
            end else if (usedw_nxt_c > ov_max_usedw) begin
                ov_max_usedw <= usedw_nxt_c;
            end

            case (state)
                O_IDLE: begin
                    if (ov_usedw != '0) begin
                        ov_descriptor   <= mem[rp];
                        o_descriptor_wr <= 1'b1;
                        state           <= O_WAIT;
                    end
                end
                O_WAIT: begin
                    if (i_descriptor_ack) begin
                        o_descriptor_wr <= 1'b0;
                        rp              <= rp + ADDR_W'(1);
                        ov_out_cnt      <= ov_out_cnt + CW'(1);
                        state           <= O_IDLE;
                    end
                end
                default: state <= O_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_host_descriptor_queue.sv
// Directed self-checking bench for host_descriptor_queue.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_host_descriptor_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] in_desc;
    logic        in_wr;
    logic        in_ack;
    logic [39:0] out_desc;
    logic        out_wr;
    logic        out_ack;
    logic [4:0]  afull_thr;
    logic        wm_clr;
    logic [4:0]  usedw;
    logic [4:0]  max_usedw;
    logic        full;
    logic        afull;
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;

    int vectors = 0;
    int miscompares = 0;

    host_descriptor_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .iv_descriptor      (in_desc),
        .i_descriptor_wr    (in_wr),
        .o_descriptor_ack   (in_ack),
        .ov_descriptor      (out_desc),
        .o_descriptor_wr    (out_wr),
        .i_descriptor_ack   (out_ack),
        .iv_afull_threshold (afull_thr),
        .i_watermark_clr    (wm_clr),
        .ov_usedw           (usedw),
        .ov_max_usedw       (max_usedw),
        .o_full             (full),
        .o_afull            (afull),
        .ov_in_cnt          (in_cnt),
        .ov_out_cnt         (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_wr = 1'b0;
        out_ack = 1'b0;
        wm_clr = 1'b0;
        in_desc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Hold wr until the accept pulse arrives, then release it.
    task automatic push(input logic [39:0] d);
        bit got_ack = 0;
        in_desc = d;
        in_wr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (in_ack) begin
                got_ack = 1;
                break;
            end
        end
        check("push_ack", 64'(got_ack), 64'd1);
        in_wr = 1'b0;
    endtask

    // Wait for a downstream request, check its payload, ack it after `dly` cycles.
    task automatic pop_expect(input logic [39:0] exp, input int dly);
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_wr) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("pop_req", 64'(seen), 64'd1);
        for (int i = 0; i < dly; i++) tick();
        check("pop_data", 64'(out_desc), 64'(exp));
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    initial begin
        int ack_seen;
        afull_thr = 5'd16;
        do_reset();

        // Reset state
        check("rst_ack", 64'(in_ack), 64'd0);
        check("rst_wr", 64'(out_wr), 64'd0);
        check("rst_desc", 64'(out_desc), 64'd0);
        check("rst_usedw", 64'(usedw), 64'd0);
        check("rst_max", 64'(max_usedw), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_afull", 64'(afull), 64'd0);
        check("rst_cnt", 64'({in_cnt, out_cnt}), 64'd0);

        // Single descriptor latency
        in_desc = 40'h12_3456_789A;
        in_wr = 1'b1;
        tick();
        check("s_ack", 64'(in_ack), 64'd1);
        check("s_usedw", 64'(usedw), 64'd1);
        check("s_wr_early", 64'(out_wr), 64'd0);
        in_wr = 1'b0;
        tick();
        check("s_ack_pulse", 64'(in_ack), 64'd0);
        check("s_wr", 64'(out_wr), 64'd1);
        check("s_desc", 64'(out_desc), 64'h12_3456_789A);
        tick();
        tick();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check("s_wr_drop", 64'(out_wr), 64'd0);
        check("s_usedw0", 64'(usedw), 64'd0);
        check("s_in_cnt", 64'(in_cnt), 64'd1);
        check("s_out_cnt", 64'(out_cnt), 64'd1);

        // Fill to full, stall the 17th, release with one downstream ack
        do_reset();
        for (int i = 0; i < 16; i++) push(40'(100 + i));
        tick();
        check("f_full", 64'(full), 64'd1);
        check("f_usedw", 64'(usedw), 64'd16);
        check("f_max", 64'(max_usedw), 64'd16);
        in_desc = 40'd200;
        in_wr = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (in_ack) ack_seen++;
        end
        check("f_stall", 64'(ack_seen), 64'd0);
        check("f_in_cnt", 64'(in_cnt), 64'd16);
        pop_expect(40'd100, 0);
        ack_seen = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (in_ack) begin
                ack_seen = 1;
                break;
            end
        end
        check("f_17th_ack", 64'(ack_seen), 64'd1);
        in_wr = 1'b0;
        for (int i = 1; i < 16; i++) pop_expect(40'(100 + i), 0);
        pop_expect(40'd200, 0);
        tick();
        check("f_cnt", 64'({in_cnt, out_cnt}), {32'd0, 16'd17, 16'd17});
        check("f_empty", 64'(usedw), 64'd0);

        // Order and pointer wrap with a concurrent downstream
        do_reset();
        fork
            for (int i = 0; i < 40; i++) push(40'(i));
            for (int i = 0; i < 40; i++) pop_expect(40'(i), 3);
        join
        tick();
        check("w_cnt", 64'({in_cnt, out_cnt}), {32'd0, 16'd40, 16'd40});
        check("w_usedw", 64'(usedw), 64'd0);
        check("w_max_le", 64'(max_usedw <= 5'd16), 64'd1);

        // Simultaneous push and pop at usedw=5
        do_reset();
        afull_thr = 5'd5;
        for (int i = 0; i < 5; i++) push(40'(300 + i));
        tick();
        check("p_usedw5", 64'(usedw), 64'd5);
        check("p_afull5", 64'(afull), 64'd1);
        check("p_head", 64'(out_desc), 64'd300);
        in_desc = 40'd305;
        in_wr = 1'b1;
        out_ack = 1'b1;
        tick();
        in_wr = 1'b0;
        out_ack = 1'b0;
        check("p_acc", 64'(in_ack), 64'd1);
        check("p_same", 64'(usedw), 64'd5);
        check("p_afull_hold", 64'(afull), 64'd1);
        afull_thr = 5'd6;
        tick();
        check("p_afull6", 64'(afull), 64'd0);
        afull_thr = 5'd0;
        tick();
        check("p_afull0", 64'(afull), 64'd1);
        afull_thr = 5'd16;
        for (int i = 1; i < 6; i++) pop_expect(40'(300 + i), 0);

        // Watermark peak, drain, clear, regrow
        do_reset();
        for (int i = 0; i < 9; i++) push(40'(400 + i));
        tick();
        check("m_peak", 64'(max_usedw), 64'd9);
        for (int i = 0; i < 7; i++) pop_expect(40'(400 + i), 0);
        tick();
        check("m_drained", 64'(usedw), 64'd2);
        check("m_hold", 64'(max_usedw), 64'd9);
        wm_clr = 1'b1;
        tick();
        wm_clr = 1'b0;
        check("m_clr", 64'(max_usedw), 64'd2);
        push(40'd409);
        check("m_regrow", 64'(max_usedw), 64'd3);

        // Reset while a descriptor is awaiting downstream ack
        do_reset();
        for (int i = 0; i < 7; i++) push(40'(500 + i));
        tick();
        check("r_wait", 64'(out_wr), 64'd1);
        check("r_usedw7", 64'(usedw), 64'd7);
        in_desc = 40'd600;
        in_wr = 1'b1;
        rst = 1'b1;
        tick();
        check("r_wr", 64'(out_wr), 64'd0);
        check("r_usedw", 64'(usedw), 64'd0);
        check("r_cnt", 64'({in_cnt, out_cnt}), 64'd0);
        check("r_noack", 64'(in_ack), 64'd0);
        in_wr = 1'b0;
        rst = 1'b0;
        tick();
        check("r_wr_post", 64'(out_wr), 64'd0);
        push(40'h55_AA55_AA55);
        check("r_post_cnt", 64'(in_cnt), 64'd1);
        pop_expect(40'h55_AA55_AA55, 1);
        tick();
        check("r_post_out", 64'(out_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
